seg7_display_ctrl: RTL

Parametrised N-digit 7-segment display controller with registered output.
Accepts a binary value on a load strobe and shows it in hex or decimal. Decimal conversion is a sequential shift-add-3 (double-dabble) engine.
Adds leading-zero blanking, overflow indication and blinking. Sits between datapath status registers and the board's static 7-segment displays.

---
 rtl/seg7_display_ctrl_if.sv | 25 ++
 rtl/seg7_display_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl_if.sv
// Signal bundle between a status-register producer and the 7-segment display controller.
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 3,
  parameter int DATA_W     = 12
);
  logic                    load;
  logic [DATA_W-1:0]       data_in;
  logic                    mode_dec;
  logic                    blank_lz;
  logic                    blink_en;
  logic                    busy;
  logic                    valid;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] seg;

  modport master (
    output load, data_in, mode_dec, blank_lz, blink_en,
    input  busy, valid, overflow, seg
  );

  modport slave (
    input  load, data_in, mode_dec, blank_lz, blink_en,
    output busy, valid, overflow, seg
  );
endinterface

// File: rtl/seg7_display_ctrl.sv
// N-digit active-low 7-segment controller: hex or double-dabble decimal, leading-zero
// blanking, overflow dashes and whole-display blinking from a registered display image.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 3,
  parameter int DATA_W     = 12,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_display_ctrl_if.slave bus
);

  localparam int BCD_W = 4*NUM_DIGITS + 4;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  function automatic longint unsigned pow10m1(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned k = 0; k < n; k++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned DEC_MAX = pow10m1(NUM_DIGITS);

  // Returned in abcdefg order (a is the MSB of the result).
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0001100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]       val, sh;
  logic                    dec_q, blz_q;
  logic [BCD_W-1:0]        bcd, adj, hexv, src;
  logic [CNT_W-1:0]        bit_cnt;
  logic [7*NUM_DIGITS-1:0] disp, disp_nxt;
  logic                    valid_q, ovf_q, ovf_nxt;
  logic [BLK_W-1:0]        blk_cnt;
  logic                    phase;
  logic                    lead;
  logic [3:0]              nib;
  logic [6:0]              g;
  int unsigned             di;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = bus.mode_dec ? CONV : UPD;
      CONV:    if (bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = UPD;
      UPD:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS + 1; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Digits are scanned from the top so blanking stops at the first nonzero digit.
  always_comb begin
    hexv     = BCD_W'(val);
    src      = dec_q ? bcd : hexv;
    ovf_nxt  = dec_q ? (64'(val) > DEC_MAX) : ((val >> (4*NUM_DIGITS)) != '0);
    lead     = blz_q;
    disp_nxt = '1;
    di       = 0;
    nib      = '0;
    g        = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      di  = NUM_DIGITS - 1 - k;
      nib = src[4*di +: 4];
      if (ovf_nxt) begin
        g = 7'b1111110;
      end else if (lead && nib == 4'd0 && di != 0) begin
        g = 7'b1111111;
      end else begin
        lead = 1'b0;
        g    = glyph(nib);
      end
      for (int unsigned b = 0; b < 7; b++) disp_nxt[7*di + b] = g[6 - b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val     <= '0;
      sh      <= '0;
      dec_q   <= 1'b0;
      blz_q   <= 1'b0;
      bcd     <= '0;
      bit_cnt <= '0;
      disp    <= '1;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.load) begin
          val     <= bus.data_in;
          sh      <= bus.data_in;
          dec_q   <= bus.mode_dec;
          blz_q   <= bus.blank_lz;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        CONV: begin
          bcd     <= BCD_W'({adj, sh[DATA_W-1]});
          sh      <= {sh[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        UPD: begin
          disp    <= disp_nxt;
          valid_q <= 1'b1;
          ovf_q   <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt <= '0;
      phase   <= ~phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.seg      = disp | {(7*NUM_DIGITS){bus.blink_en & phase}};

endmodule
